// File: rtl/pipe_io_responder.sv
// rtl/pipe_io_responder.sv - MEM-stage I/O register window: RX FIFO, TX valid/ack handshake, status.
// Optional RX interrupt enable in CTRL is built only when PIPE_IO_IRQ_EN is defined.
module pipe_io_responder #(
    parameter logic [31:0] IO_BASE  = 32'h0000_0080,
    parameter int          RX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [31:0] ext_in_data,
    input  logic        ext_in_valid,
    output logic        ext_in_ready,
    output logic [31:0] ext_out_data,
    output logic        ext_out_valid,
    input  logic        ext_out_ack,
    output logic        irq
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    tx_state_t         tx_state_q, tx_state_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              tx_overrun_q, tx_overrun_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rx_count_q, rx_count_d;
    logic              in_en_q, in_en_d;
    logic [31:0]       rx_mem_q [RX_DEPTH];

    logic              sel;
    logic [1:0]        reg_idx;
    logic              rx_nonempty;
    logic              rx_full;
    logic              tx_busy;
    logic              push_en;
    logic              pop_en;
    logic              wr_status;
    logic              wr_txdata;
    logic              wr_ctrl;
    logic [3:0]        rx_count4;
    logic [31:0]       status_word;
    logic [31:0]       ctrl_word;
    logic              unused_bits;

    assign sel         = (addr[31:4] == IO_BASE[31:4]);
    assign reg_idx     = addr[3:2];
    assign unused_bits = ^{addr[1:0], wr_ctrl};

    assign rx_nonempty = (rx_count_q != '0);
    assign rx_full     = (rx_count_q == CW'(RX_DEPTH));
    assign tx_busy     = (tx_state_q == TX_BUSY);

    // Ready stays low until the first edge after reset release.
    assign ext_in_ready = in_en_q && !rx_full;
    assign push_en      = ext_in_valid && ext_in_ready;
    assign pop_en       = re && sel && (reg_idx == REG_RXDATA) && rx_nonempty;

    assign wr_status = we && sel && (reg_idx == REG_STATUS);
    assign wr_txdata = we && sel && (reg_idx == REG_TXDATA);
    assign wr_ctrl   = we && sel && (reg_idx == REG_CTRL);

    assign rx_count4   = 4'(rx_count_q);
    assign status_word = {24'b0, rx_count4, tx_overrun_q, tx_busy, rx_full, rx_nonempty};

    assign ext_out_data  = tx_data_q;
    assign ext_out_valid = tx_busy;

`ifdef PIPE_IO_IRQ_EN
    logic rx_ie_q, rx_ie_d;

    always_comb begin
        rx_ie_d = rx_ie_q;
        if (wr_ctrl) begin
            rx_ie_d = wdata[0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_ie_q <= 1'b0;
        end else begin
            rx_ie_q <= rx_ie_d;
        end
    end

    assign ctrl_word = {31'b0, rx_ie_q};
    assign irq       = rx_ie_q && rx_nonempty;
`else
    assign ctrl_word = 32'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rx_count_d = rx_count_q;
        in_en_d    = 1'b1;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   rx_count_d = rx_count_q + CW'(1);
            2'b01:   rx_count_d = rx_count_q - CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // A store that lands while BUSY is lost even if the ack arrives in the same cycle.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_data_d    = tx_data_q;
        tx_overrun_d = tx_overrun_q;
        if (wr_status && wdata[3]) begin
            tx_overrun_d = 1'b0;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_txdata) begin
                    tx_data_d  = wdata;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (wr_txdata) begin
                    tx_overrun_d = 1'b1;
                end
                if (ext_out_ack) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_state_q   <= TX_IDLE;
            tx_data_q    <= 32'b0;
            tx_overrun_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rx_count_q   <= '0;
            in_en_q      <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_data_q    <= tx_data_d;
            tx_overrun_q <= tx_overrun_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rx_count_q   <= rx_count_d;
            in_en_q      <= in_en_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clock) begin
        if (push_en) begin
            rx_mem_q[wr_ptr_q] <= ext_in_data;
        end
    end

    always_comb begin
        rdata = 32'b0;
        if (re && sel) begin
            case (reg_idx)
                REG_STATUS: rdata = status_word;
                REG_RXDATA: rdata = rx_nonempty ? rx_mem_q[rd_ptr_q] : 32'b0;
                REG_CTRL:   rdata = ctrl_word;
                default:    rdata = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_io_responder.sv
// tb/tb_pipe_io_responder.sv - bench for pipe_io_responder: vector table, directed TX/reset sequences, random vs model.
module tb_pipe_io_responder;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] addr, wdata, rdata, ext_in_data, ext_out_data;
    logic        we, re, ext_in_valid, ext_in_ready, ext_out_valid, ext_out_ack, irq;

    int tests = 0;
    int fails = 0;

    pipe_io_responder #(.IO_BASE(32'h0000_0080), .RX_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
        .ext_in_ready(ext_in_ready), .ext_out_data(ext_out_data),
        .ext_out_valid(ext_out_valid), .ext_out_ack(ext_out_ack), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        re;
        logic        iv;
        logic [31:0] idata;
        logic [31:0] e_rdata;
        logic        e_ready;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] m_q[$];
    logic        m_busy, m_ovr, m_ie;
    logic [31:0] m_data;

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                input logic r, input logic v, input logic [31:0] d,
                                input logic [31:0] er, input logic ey);
        vec_t t;
        t.addr = a; t.we = w; t.wdata = wd; t.re = r; t.iv = v; t.idata = d;
        t.e_rdata = er; t.e_ready = ey;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        ext_in_valid = 1'b0; ext_in_data = 32'h0; ext_out_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic r);
        logic [31:0] st;
        int n;
        n = m_q.size();
        if (!r || a[31:4] != 28'h0000008) return 32'h0;
        case (a[3:2])
            2'd0: begin
                st = 32'h0;
                st[7:4] = 4'(n);
                st[3] = m_ovr;
                st[2] = m_busy;
                st[1] = (n == DEPTH);
                st[0] = (n > 0);
                return st;
            end
            2'd1:    return (n > 0) ? m_q[0] : 32'h0;
            2'd3:    return {31'h0, m_ie};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_edge();
        logic sel, pop, push;
        sel  = (addr[31:4] == 28'h0000008);
        pop  = re && sel && addr[3:2] == 2'd1 && m_q.size() > 0;
        push = ext_in_valid && m_q.size() < DEPTH;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(ext_in_data);
        if (we && sel && addr[3:2] == 2'd0 && wdata[3]) m_ovr = 1'b0;
`ifdef PIPE_IO_IRQ_EN
        if (we && sel && addr[3:2] == 2'd3) m_ie = wdata[0];
`endif
        if (m_busy) begin
            if (we && sel && addr[3:2] == 2'd2) m_ovr = 1'b1;
            if (ext_out_ack) m_busy = 1'b0;
        end else if (we && sel && addr[3:2] == 2'd2) begin
            m_busy = 1'b1;
            m_data = wdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        resetn = 1'b0;

        // Outputs inert while reset is held, even with active inputs.
        #1 re = 1'b1; addr = 32'h80; ext_in_valid = 1'b1; ext_out_ack = 1'b1;
        #1;
        check("rst_ready", ext_in_ready, 0);
        check("rst_valid", ext_out_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", rdata, 0);
        tick();
        check("rst_ready_edge", ext_in_ready, 0);
        check("rst_outdata", ext_out_data, 0);
        do_reset();

        tbl.push_back(mk(32'h00, 0, 0, 0, 1, 32'h11, 32'h0, 1));
        tbl.push_back(mk(32'h00, 0, 0, 0, 1, 32'h22, 32'h0, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h11, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h22, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h00, 1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(32'h00, 0, 0, 0, 1, 32'hA0 + k, 32'h0, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 1, 32'hA4, 32'h43, 0));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'hA0, 0));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h31, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'hA1, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'hA2, 1));
        tbl.push_back(mk(32'h87, 0, 0, 1, 0, 0, 32'hA3, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h88, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h8C, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h90, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h7C, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h84, 0, 0, 0, 1, 32'h55, 32'h0, 1));
        tbl.push_back(mk(32'h84, 0, 0, 0, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h84, 1, 32'hFFFF_FFFF, 1, 0, 0, 32'h55, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h00, 1));
        tbl.push_back(mk(32'h00, 0, 0, 0, 1, 32'h66, 32'h0, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 1, 32'h77, 32'h66, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h11, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h77, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 1, 32'h88, 32'h00, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h11, 1));
        tbl.push_back(mk(32'h84, 0, 0, 1, 0, 0, 32'h88, 1));
        tbl.push_back(mk(32'h80, 0, 0, 1, 0, 0, 32'h00, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            addr = tbl[i].addr; we = tbl[i].we; wdata = tbl[i].wdata; re = tbl[i].re;
            ext_in_valid = tbl[i].iv; ext_in_data = tbl[i].idata;
            @(negedge clock);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
            check($sformatf("vec%0d_ready", i), ext_in_ready, 32'(tbl[i].e_ready));
            check($sformatf("vec%0d_valid", i), ext_out_valid, 0);
            tick();
        end
        idle();

        ext_out_ack = 1'b1;
        tick();
        check("ack_idle_valid", ext_out_valid, 0);
        ext_out_ack = 1'b0;
        addr = 32'h88; wdata = 32'hDEAD_BEEF; we = 1'b1;
        #1 check("tx_pre_valid", ext_out_valid, 0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("tx_hold%0d_valid", k), ext_out_valid, 1);
            check($sformatf("tx_hold%0d_data", k), ext_out_data, 32'hDEAD_BEEF);
            tick();
        end
        addr = 32'h88; wdata = 32'h1; we = 1'b1;
        tick();
        idle();
        addr = 32'h80; re = 1'b1;
        #1;
        check("ovr_status", rdata, 32'h0C);
        check("ovr_data", ext_out_data, 32'hDEAD_BEEF);
        re = 1'b0;
        ext_out_ack = 1'b1;
        #1 check("ack_cycle_valid", ext_out_valid, 1);
        tick();
        ext_out_ack = 1'b0;
        #1 check("after_ack_valid", ext_out_valid, 0);
        re = 1'b1;
        #1 check("after_ack_status", rdata, 32'h08);
        re = 1'b0; we = 1'b1; wdata = 32'h8;
        tick();
        we = 1'b0; re = 1'b1;
        #1 check("ovr_cleared", rdata, 32'h00);
        idle();
        addr = 32'h88; we = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        wdata = 32'h1234_5678; ext_out_ack = 1'b1;
        tick();
        idle();
        addr = 32'h80; re = 1'b1;
        #1;
        check("ackdrop_status", rdata, 32'h08);
        check("ackdrop_valid", ext_out_valid, 0);
        check("ackdrop_data", ext_out_data, 32'hCAFE_F00D);
        re = 1'b0; we = 1'b1; wdata = 32'h8;
        tick();
        idle();

`ifdef PIPE_IO_IRQ_EN
        addr = 32'h8C; we = 1'b1; wdata = 32'h1;
        tick();
        we = 1'b0; re = 1'b1;
        #1 check("ctrl_read", rdata, 32'h1);
        check("irq_empty", irq, 0);
        idle();
        ext_in_valid = 1'b1; ext_in_data = 32'h99;
        tick();
        idle();
        #1 check("irq_set", irq, 1);
        addr = 32'h84; re = 1'b1;
        #1 check("irq_pop_data", rdata, 32'h99);
        tick();
        idle();
        #1 check("irq_clear", irq, 0);
        addr = 32'h8C; we = 1'b1; wdata = 32'h0;
        tick();
        idle();
`else
        addr = 32'h8C; we = 1'b1; wdata = 32'h1;
        tick();
        we = 1'b0; re = 1'b1;
        #1 check("ctrl_read_off", rdata, 32'h0);
        idle();
        ext_in_valid = 1'b1; ext_in_data = 32'h99;
        tick();
        idle();
        #1 check("irq_off", irq, 0);
        addr = 32'h84; re = 1'b1;
        tick();
        idle();
`endif

        ext_in_valid = 1'b1; ext_in_data = 32'h1111;
        tick();
        ext_in_data = 32'h2222;
        tick();
        idle();
        addr = 32'h88; we = 1'b1; wdata = 32'h5A5A_5A5A;
        tick();
        idle();
        addr = 32'h84; re = 1'b1; ext_in_valid = 1'b1;
        #1;
        check("prerst_head", rdata, 32'h1111);
        check("prerst_valid", ext_out_valid, 1);
        resetn = 1'b0;
        #1;
        check("midrst_ready", ext_in_ready, 0);
        check("midrst_valid", ext_out_valid, 0);
        check("midrst_data", ext_out_data, 0);
        check("midrst_irq", irq, 0);
        check("midrst_rdata", rdata, 0);
        idle();
        tick();
        resetn = 1'b1;
        #1 check("release_ready", ext_in_ready, 0);
        tick();
        check("post_ready", ext_in_ready, 1);
        addr = 32'h80; re = 1'b1;
        #1 check("post_status", rdata, 32'h0);
        addr = 32'h84;
        #1 check("post_rxdata", rdata, 32'h0);
        idle();

        do_reset();
        m_q.delete();
        m_busy = 1'b0; m_ovr = 1'b0; m_ie = 1'b0; m_data = 32'h0;
        for (int c = 0; c < 500; c++) begin
            case ($urandom_range(0, 5))
                0: addr = 32'h80;
                1: addr = 32'h84;
                2: addr = 32'h88;
                3: addr = 32'h8C;
                4: addr = 32'h90;
                default: addr = $urandom;
            endcase
            addr = addr | 32'($urandom_range(0, 3));
            wdata = $urandom;
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 1) == 0);
            ext_in_valid = ($urandom_range(0, 1) == 0);
            ext_in_data = $urandom;
            ext_out_ack = ($urandom_range(0, 2) == 0);
            #1;
            check($sformatf("rnd%0d_rdata", c), rdata, m_rdata(addr, re));
            check($sformatf("rnd%0d_ready", c), ext_in_ready, 32'(m_q.size() < DEPTH));
            check($sformatf("rnd%0d_valid", c), ext_out_valid, 32'(m_busy));
            check($sformatf("rnd%0d_odata", c), ext_out_data, m_data);
            check($sformatf("rnd%0d_irq", c), irq, 32'(m_ie && m_q.size() > 0));
            @(posedge clock);
            m_edge();
            #1;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
